aes128: RTL and testbench
=========================

Name: aes128

Overview:
- Fully unrolled, pipelined AES-128 encryption core (FIPS-197 cipher, encrypt only), one block per clock of throughput.
- Takes a 128-bit plaintext and a 128-bit cipher key as four 32-bit words each and returns the 128-bit ciphertext as four 32-bit words.
- Sits as a free-running datapath block with no handshake: the result for whatever is on the inputs appears a fixed number of cycles later.

Parameters:
- None. Key size fixed at 128 bits, 10 rounds.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- inp_data_0  input  32  plaintext bits [31:0] (least significant word).
- inp_data_1  input  32  plaintext bits [63:32].
- inp_data_2  input  32  plaintext bits [95:64].
- inp_data_3  input  32  plaintext bits [127:96] (most significant word, FIPS state column 0).
- inp_key_0..inp_key_3  input  32 each  cipher key, same word ordering as data (inp_key_3 = key bits [127:96]).
- out_data_0..out_data_3  output  32 each  ciphertext, same word ordering (out_data_3 = bits [127:96]).

Behaviour:
- Byte mapping: 128-bit value V = {w3,w2,w1,w0}; FIPS byte 0 = V[127:120], byte 15 = V[7:0]. Bytes fill the state column-major: w3 = column 0, w0 = column 3.
- Stage 0 (registered): state0 = plaintext XOR key; roundkey0 = key is registered alongside.
- Stages 1..9 (each registered): SubBytes, ShiftRows, MixColumns, AddRoundKey with round key r. Each stage computes its round key combinationally from the previous stage's registered key (RotWord, SubWord, Rcon r: 01,02,04,08,10,20,40,80,1b,36) and registers it with the state.
- Stage 10 (registered, drives outputs): SubBytes, ShiftRows, AddRoundKey (no MixColumns).
- Latency: inputs sampled at rising edge N appear on out_data_* after edge N+10 (11 register stages, 11 cycles). Throughput one block per cycle; inputs may change every cycle with independent results.
- No start/valid: outputs for a stable input become correct 11 cycles after the input settles, with or without a prior reset.
- Reset: when reset=1 at a rising edge, all pipeline state and key registers and all outputs clear to 0. Outputs read 32'h0 while reset held and for the cycles until the first post-reset input has traversed the pipeline (pipeline then carries results of zero-filled stages, which are don't-care to consumers).
- Reset mid-operation: in-flight blocks are discarded; no partial results appear afterwards.
- S-box: standard AES forward S-box; either a 256-entry lookup function or GF(2^8) inverse + affine transform. Shared function used for SubBytes and SubWord (20 instances per round stage).
- MixColumns: GF(2^8) with polynomial x^8+x^4+x^3+x+1 (xtime: shift left, XOR 8'h1b if MSB set).
- No decryption, no key caching across blocks; key may change every cycle.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff held stable, reset low throughout -> {out_data_3..0} = 69c4e0d86a7b0430d8cdb78070b4c55a from cycle 11 onward, checked at ~30 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Back-to-back: apply vector C.1 then App. B on consecutive cycles after reset -> results on consecutive cycles exactly 11 cycles after each input, no interference.
- Reset: assert reset 2 cycles -> all out_data_* = 0 the cycle after; deassert with C.1 applied -> outputs 0 until C.1 ciphertext appears 11 cycles later.
- Reset mid-stream: stream blocks, pulse reset for 1 cycle -> outputs go 0, pre-reset blocks never emerge; blocks applied after reset emerge correctly.
- Latency check: change plaintext at a known edge -> output changes exactly 11 edges later, not earlier.

Source files
------------

// File: rtl/aes128.sv
// Fully unrolled AES-128 encryption pipeline: one block per clock, 11 register stages.
// Word 3 of each 128-bit value is the most significant word and FIPS state column 0.
module aes128 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inp_data_0,
  input  logic [31:0] inp_data_1,
  input  logic [31:0] inp_data_2,
  input  logic [31:0] inp_data_3,
  input  logic [31:0] inp_key_0,
  input  logic [31:0] inp_key_1,
  input  logic [31:0] inp_key_2,
  input  logic [31:0] inp_key_3,
  output logic [31:0] out_data_0,
  output logic [31:0] out_data_1,
  output logic [31:0] out_data_2,
  output logic [31:0] out_data_3
);

  localparam int unsigned Rounds = 10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int r);
    case (r)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  // Byte (row r, column c) lives at bit 127 - 8*(r + 4*c); ShiftRows pulls from column c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] state_q [Rounds];
  logic [127:0] key_q   [Rounds];
  logic [127:0] state_d [Rounds];
  logic [127:0] key_d   [Rounds];
  logic [Rounds-1:0] valid_q;
  logic [127:0] out_q;

  // Entry r-1 of the _d arrays holds the combinational result of round r.
  always_comb begin : round_logic
    logic [127:0] sb;
    sb = '0;
    for (int r = 1; r <= Rounds; r++) begin
      key_d[r-1]   = next_key(key_q[r-1], rcon(r));
      sb           = sub_shift(state_q[r-1]);
      state_d[r-1] = ((r == Rounds) ? sb : mix_columns(sb)) ^ key_d[r-1];
    end
  end

  // valid_q masks the zero-filled stages left behind by reset so outputs stay 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Rounds; i++) begin
        state_q[i] <= '0;
        key_q[i]   <= '0;
      end
      valid_q <= '0;
      out_q   <= '0;
    end else begin
      state_q[0] <= {inp_data_3, inp_data_2, inp_data_1, inp_data_0} ^
                    {inp_key_3, inp_key_2, inp_key_1, inp_key_0};
      key_q[0]   <= {inp_key_3, inp_key_2, inp_key_1, inp_key_0};
      for (int i = 1; i < Rounds; i++) begin
        state_q[i] <= state_d[i-1];
        key_q[i]   <= key_d[i-1];
      end
      valid_q <= {valid_q[Rounds-2:0], 1'b1};
      out_q   <= valid_q[Rounds-1] ? state_d[Rounds-1] : '0;
    end
  end

  assign out_data_3 = out_q[127:96];
  assign out_data_2 = out_q[95:64];
  assign out_data_1 = out_q[63:32];
  assign out_data_0 = out_q[31:0];

endmodule

// File: tb/tb_aes128.sv
// Directed bench for aes128: FIPS-197 vectors, back-to-back blocks, latency and reset.
module tb_aes128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inp_data_0, inp_data_1, inp_data_2, inp_data_3;
  logic [31:0] inp_key_0, inp_key_1, inp_key_2, inp_key_3;
  logic [31:0] out_data_0, out_data_1, out_data_2, out_data_3;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CtZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128 dut (
    .clk        (clk),
    .reset      (reset),
    .inp_data_0 (inp_data_0),
    .inp_data_1 (inp_data_1),
    .inp_data_2 (inp_data_2),
    .inp_data_3 (inp_data_3),
    .inp_key_0  (inp_key_0),
    .inp_key_1  (inp_key_1),
    .inp_key_2  (inp_key_2),
    .inp_key_3  (inp_key_3),
    .out_data_0 (out_data_0),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2),
    .out_data_3 (out_data_3)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [127:0] pt, input logic [127:0] key);
    {inp_data_3, inp_data_2, inp_data_1, inp_data_0} = pt;
    {inp_key_3, inp_key_2, inp_key_1, inp_key_0}     = key;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] expected);
    logic [127:0] observed;
    observed = {out_data_3, out_data_2, out_data_1, out_data_0};
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // C.1 with no reset ever applied.
    apply(PtC1, KeyC1);
    step(30);
    check("c1_noreset", CtC1);

    // App. B directly: change inputs, wait full latency.
    apply(PtB, KeyB);
    step(11);
    check("appb", CtB);

    // Reset held two cycles, then released with C.1 applied.
    reset = 1'b1;
    apply(PtC1, KeyC1);
    step(1);
    check("reset_1", '0);
    step(1);
    check("reset_2", '0);
    reset = 1'b0;
    step(5);
    check("post_reset_5", '0);
    step(5);
    check("post_reset_10", '0);
    step(1);
    check("post_reset_c1", CtC1);

    // Back-to-back: C.1, App. B, all-zero on consecutive edges after reset.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    apply(PtC1, KeyC1);
    step(1);
    apply(PtB, KeyB);
    step(1);
    apply('0, '0);
    step(1);
    step(7);
    check("b2b_before", '0);
    step(1);
    check("b2b_c1", CtC1);
    step(1);
    check("b2b_appb", CtB);
    step(1);
    check("b2b_zero", CtZ);
    step(3);
    check("b2b_zero_hold", CtZ);

    // Latency: output must not change before the 11th edge.
    apply(PtB, KeyB);
    step(10);
    check("latency_early", CtZ);
    step(1);
    check("latency_exact", CtB);

    // Mid-stream reset: in-flight blocks must never emerge.
    apply(PtC1, KeyC1);
    step(1);
    apply(PtB, KeyB);
    step(1);
    reset = 1'b1;
    step(1);
    check("midreset_pulse", '0);
    reset = 1'b0;
    apply('0, '0);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check($sformatf("midreset_flush_%0d", i), '0);
    end
    step(1);
    check("midreset_zero", CtZ);
    apply(PtC1, KeyC1);
    step(11);
    check("midreset_c1", CtC1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
